// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter serialising JK-style updates to a shared bit bank.
// Define JK_ARB_LOCK_EN to add the lock port for back-to-back burst ownership.
module jk_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] j_in,
  input  logic [NREQ*WIDTH-1:0] k_in,
`ifdef JK_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, GRANT, APPLY} state_t;
  state_t state, nstate;
  logic [PW-1:0] ptr, nptr, win, nwin;
  logic [WIDTH-1:0] jc, kc;
  logic [NREQ-1:0] cand, gnt_d;
  logic [PW:0] pk;
  logic relock, busy_d;
  // returns {found, index} of the first set bit at or after p, wrapping
  function automatic logic [PW:0] pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW:0] res;
    int k;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NREQ;
      if (r[k]) res = {1'b1, PW'(k)};
    end
    return res;
  endfunction
`ifdef JK_ARB_LOCK_EN
  logic lk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lk <= 1'b0;
    else if (state == GRANT) lk <= lock[win];
  assign relock = state == APPLY && lk && req[win];
`else
  assign relock = 1'b0;
`endif
  // the requester just served is ignored while its req is still dropping
  always_comb begin
    cand = state == APPLY ? req & ~(NREQ'(1) << win) : req;
    pk = pick(cand, ptr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
    end else begin
      state <= nstate;
      ptr <= nptr;
      win <= nwin;
    end
  always_comb begin
    nstate = state;
    nptr = ptr;
    nwin = win;
    if (state == GRANT) nstate = APPLY;
    else if (relock) nstate = GRANT;
    else if (pk[PW]) begin
      nstate = GRANT;
      nwin = pk[PW-1:0];
      nptr = PW'((int'(pk[PW-1:0]) + 1) % NREQ);
    end else if (state == APPLY) nstate = IDLE;
  end
  always_comb begin
    gnt_d = nstate == GRANT ? NREQ'(1) << nwin : '0;
    busy_d = nstate != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt <= '0;
      busy <= 1'b0;
      q <= '0;
      jc <= '0;
      kc <= '0;
    end else begin
      gnt <= gnt_d;
      busy <= busy_d;
      if (state == GRANT) begin
        jc <= j_in[int'(win)*WIDTH +: WIDTH];
        kc <= k_in[int'(win)*WIDTH +: WIDTH];
      end
      if (state == APPLY) q <= (jc & ~q) | (~kc & q);
    end
endmodule
